dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared single-port data memory of the single-cycle core. Requester 0 is the CPU load/store path. Requester 1 is the program/data loader. The block serialises their accesses with round-robin priority, drives the memory port for a fixed read latency, and returns a one-cycle ack with registered read data.

---
 rtl/dmem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port data memory (CPU = rq0, loader = rq1).
// Optional macro DMEM_ARB_LOCK_EN adds rq0_lock/rq1_lock for bounded back-to-back re-grants.
module dmem_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rq0_req,
    input  logic          rq0_we,
    input  logic [AW-1:0] rq0_addr,
    input  logic [DW-1:0] rq0_wdata,
    input  logic          rq1_req,
    input  logic          rq1_we,
    input  logic [AW-1:0] rq1_addr,
    input  logic [DW-1:0] rq1_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          rq0_lock,
    input  logic          rq1_lock,
`endif
    output logic          rq0_ack,
    output logic [DW-1:0] rq0_rdata,
    output logic          rq1_ack,
    output logic [DW-1:0] rq1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          arb_busy,
    output logic          arb_owner
);

    localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_chk
        $error("dmem_arbiter: RD_LAT must be in 1..4");
    end
    if (LOCK_MAX < 1) begin : g_lock_max_chk
        $error("dmem_arbiter: LOCK_MAX must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          gnt_id_q, gnt_id_d;
    logic          gnt_we_q, gnt_we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          busy_q, busy_d;
    logic          owner_q, owner_d;
    logic          win;

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);
    logic          lock_hold_q, lock_hold_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          last_req;
    logic          win_lock;
`endif

    // Next-state, grant selection and registered-output precomputation
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_we_d    = gnt_we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        owner_d     = owner_q;
        win         = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock_hold_d = lock_hold_q;
        lock_cnt_d  = lock_cnt_q;
        last_req    = last_gnt_q ? rq1_req : rq0_req;
        win_lock    = gnt_id_q ? rq1_lock : rq0_lock;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (rq0_req && rq1_req) begin
                    win = ~last_gnt_q;
                end else begin
                    win = rq1_req;
                end
`ifdef DMEM_ARB_LOCK_EN
                // A lock only survives into the IDLE cycle right after RESP
                lock_hold_d = 1'b0;
                if (rq0_req || rq1_req) begin
                    if (lock_hold_q && last_req) begin
                        win        = last_gnt_q;
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
`endif
                if (rq0_req || rq1_req) begin
                    gnt_id_d    = win;
                    gnt_we_d    = win ? rq1_we : rq0_we;
                    owner_d     = win;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win ? rq1_we : rq0_we;
                    mem_addr_d  = win ? rq1_addr : rq0_addr;
                    mem_wdata_d = win ? rq1_wdata : rq0_wdata;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gnt_we_q) begin
                    ack0_d  = ~gnt_id_q;
                    ack1_d  = gnt_id_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Last latency cycle: memory data is valid now
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    if (gnt_id_q) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                    ack0_d  = ~gnt_id_q;
                    ack1_d  = gnt_id_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                last_gnt_d = gnt_id_q;
`ifdef DMEM_ARB_LOCK_EN
                lock_hold_d = win_lock && (lock_cnt_q < LW'(LOCK_MAX));
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= 1'b1;
            gnt_id_q    <= 1'b0;
            gnt_we_q    <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            lock_hold_q <= 1'b0;
            lock_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_we_q    <= gnt_we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_hold_q <= lock_hold_d;
            lock_cnt_q  <= lock_cnt_d;
`endif
        end
    end

    assign rq0_ack   = ack0_q;
    assign rq1_ack   = ack1_q;
    assign rq0_rdata = rdata0_q;
    assign rq1_rdata = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign arb_busy  = busy_q;
    assign arb_owner = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: predicted grants/cycles are queued at stimulus time and
// popped on each ack; a RAM model drives mem_rdata valid only in the exact latency cycle.
module tb_dmem_arbiter;

    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 32;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned LOCK_MAX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rq0_req = 1'b0, rq1_req = 1'b0;
    logic          rq0_we = 1'b0, rq1_we = 1'b0;
    logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
    logic [DW-1:0] rq0_wdata = '0, rq1_wdata = '0;
    logic          rq0_ack, rq1_ack;
    logic [DW-1:0] rq0_rdata, rq1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          arb_busy, arb_owner;
    logic          lk [2];

    dmem_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .rq0_lock(lk[0]), .rq1_lock(lk[1]),
`endif
        .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
        .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RAM model: read data appears only in the cycle RD_LAT after the mem_en cycle
    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] pipe_d [RD_LAT];
    logic          pipe_v [RD_LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        pipe_d[0] <= ram[mem_addr];
        pipe_v[0] <= mem_en && !mem_we;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end

    assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : (32'hBAD0_0000 ^ DW'(cyc));

    typedef struct {
        logic          id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            iss;
        int            ack;
    } exp_t;

    exp_t          sbq [$];
    exp_t          mon_e;
    logic [DW-1:0] rd_exp [2];
    bit            sb_on = 1'b0;
    logic          last_m = 1'b1;

    logic          p_we   [2][16];
    logic [AW-1:0] p_addr [2][16];
    logic [DW-1:0] p_wd   [2][16];

    // Monitor: memory port against the head transaction, acks pop the scoreboard
    always @(negedge clk) begin
        if (sb_on && rst) begin
            if (mem_en) begin
                if (sbq.size() == 0) begin
                    check("mem_en_unexpected", 1, 0);
                end else begin
                    mon_e = sbq[0];
                    check("issue_cycle", 64'(cyc), 64'(mon_e.iss));
                    check("mem_we", mem_we, mon_e.we);
                    check("mem_addr", mem_addr, mon_e.addr);
                    if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wdata);
                    check("arb_owner", arb_owner, mon_e.id);
                    check("busy_issue", arb_busy, 1);
                end
            end else begin
                check("idle_port_zero", {mem_we, mem_addr, mem_wdata}, 0);
            end
            if (rq0_ack || rq1_ack) begin
                check("single_ack", rq0_ack & rq1_ack, 0);
                if (sbq.size() == 0) begin
                    check("ack_unexpected", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("ack_id", rq1_ack, mon_e.id);
                    check("ack_cycle", 64'(cyc), 64'(mon_e.ack));
                    if (!mon_e.we) rd_exp[mon_e.id] = mon_e.rdata;
                    check("rq0_rdata", rq0_rdata, rd_exp[0]);
                    check("rq1_rdata", rq1_rdata, rd_exp[1]);
                    check("busy_resp", arb_busy, 1);
                end
            end
        end
    end

    task automatic drive(input int id, input int k, input bit on);
        if (id == 0) begin
            rq0_req = on;
            if (on) begin rq0_we = p_we[0][k]; rq0_addr = p_addr[0][k]; rq0_wdata = p_wd[0][k]; end
        end else begin
            rq1_req = on;
            if (on) begin rq1_we = p_we[1][k]; rq1_addr = p_addr[1][k]; rq1_wdata = p_wd[1][k]; end
        end
    endtask

    task automatic fill_rand(input int id, input int n, input int wr_only);
        for (int i = 0; i < n; i++) begin
            p_we[id][i]   = (wr_only != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            p_addr[id][i] = AW'($urandom_range(0, 15));
            p_wd[id][i]   = $urandom;
        end
    endtask

    // Both requesters hold req until their n-th ack; grants/cycles predicted up front
    task automatic stream(input int n0, input int n1);
        int   rem [2];
        int   k [2];
        int   t;
        int   lcnt;
        int   budget;
        logic last;
        logic w;
        bit   hold;
        exp_t e;

        repeat (2) @(negedge clk);
        rem[0] = n0; rem[1] = n1; k[0] = 0; k[1] = 0;
        t = cyc; last = last_m; hold = 1'b0; lcnt = 0;
        for (int g = 0; g < n0 + n1; g++) begin
            if (hold && rem[last] > 0) begin
                w = last;
                lcnt++;
            end else begin
                w = (rem[0] > 0 && rem[1] > 0) ? ~last : (rem[1] > 0);
                lcnt = 0;
            end
            e.id = w; e.we = p_we[w][k[w]]; e.addr = p_addr[w][k[w]]; e.wdata = p_wd[w][k[w]];
            e.rdata = shadow[e.addr];
            if (e.we) shadow[e.addr] = e.wdata;
            e.iss = t + 1;
            e.ack = e.we ? t + 2 : t + int'(RD_LAT) + 2;
            sbq.push_back(e);
            t = e.ack + 1; k[w]++; rem[w]--; last = w;
            hold = lk[w] && (lcnt < int'(LOCK_MAX));
        end
        last_m = last;

        rem[0] = n0; rem[1] = n1; k[0] = 0; k[1] = 0;
        drive(0, 0, n0 > 0);
        drive(1, 0, n1 > 0);
        budget = 0;
        while ((rem[0] + rem[1]) > 0 && budget < 400) begin
            @(negedge clk);
            budget++;
            if (rq0_ack && rem[0] > 0) begin rem[0]--; k[0]++; drive(0, k[0], rem[0] > 0); end
            if (rq1_ack && rem[1] > 0) begin rem[1]--; k[1]++; drive(1, k[1], rem[1] > 0); end
        end
        if (budget >= 400) begin
            check("stream_timeout", 64'(rem[0] + rem[1]), 0);
            rq0_req = 1'b0; rq1_req = 1'b0;
            sbq.delete();
        end
        @(negedge clk);
        check("busy_after_stream", arb_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int guard;
        lk[0] = 1'b0; lk[1] = 1'b0;
        rd_exp[0] = '0; rd_exp[1] = '0;
        for (int i = 0; i < RD_LAT; i++) pipe_v[i] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            ram[a]    = {8'(a), ~8'(a), 8'(a) ^ 8'h5A, 8'h3C};
            shadow[a] = ram[a];
        end
        ram[8'h2A]    = 32'h1234_5678;
        shadow[8'h2A] = 32'h1234_5678;

        // Reset held with random inputs: all outputs quiet
        repeat (5) begin
            @(negedge clk);
            rq0_req = 1'($urandom); rq1_req = 1'($urandom);
            rq0_we = 1'($urandom); rq1_we = 1'($urandom);
            rq0_addr = AW'($urandom); rq1_addr = AW'($urandom);
            rq0_wdata = $urandom; rq1_wdata = $urandom;
        end
        #1;
        check("rst_ctrl", {rq0_ack, rq1_ack, arb_busy, arb_owner, mem_en, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", {rq0_rdata, rq1_rdata}, 0);
        @(negedge clk);
        rq0_req = 1'b0; rq1_req = 1'b0;
        rst = 1'b1;
        sb_on = 1'b1;

        // rq0 write of 0xDEADBEEF to 0x10
        p_we[0][0] = 1'b1; p_addr[0][0] = 8'h10; p_wd[0][0] = 32'hDEAD_BEEF;
        stream(1, 0);

        // rq1 read of 0x2A; rq0_rdata must stay untouched
        p_we[1][0] = 1'b0; p_addr[1][0] = 8'h2A; p_wd[1][0] = $urandom;
        stream(0, 1);

        // Continuous writes from both sides: acks at T+2, T+5, T+8
        fill_rand(0, 2, 1);
        fill_rand(1, 1, 1);
        stream(2, 1);

        // Mixed reads/writes over a small address range
        fill_rand(0, 6, 0);
        fill_rand(1, 6, 0);
        stream(6, 6);

        // rq1 alone, then a tie which rq0 must win
        fill_rand(1, 1, 0);
        stream(0, 1);
        fill_rand(0, 1, 0);
        fill_rand(1, 1, 0);
        stream(1, 1);

        // Reset in the second WAIT cycle of a read
        @(negedge clk);
        sb_on = 1'b0;
        rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 8'h05;
        rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 8'h06;
        t0 = cyc; guard = 0;
        while (cyc < t0 + 3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("busy_in_wait", arb_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", arb_busy, 0);
        check("async_rst_en_ack", {mem_en, rq0_ack, rq1_ack}, 0);
        check("async_rst_owner", arb_owner, 0);
        check("async_rst_rdata", {rq0_rdata, rq1_rdata}, 0);
        rq0_req = 1'b0; rq1_req = 1'b0;
        sbq.delete();
        rd_exp[0] = '0; rd_exp[1] = '0;
        last_m = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb_on = 1'b1;
        fill_rand(0, 1, 0);
        fill_rand(1, 1, 0);
        stream(1, 1);

`ifdef DMEM_ARB_LOCK_EN
        // rq1 locked after an rq0 grant: expected order 1,1,1,0,1
        fill_rand(0, 1, 1);
        stream(1, 0);
        lk[1] = 1'b1;
        fill_rand(0, 1, 1);
        fill_rand(1, 4, 1);
        stream(1, 4);
        lk[1] = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
